hci_periph_rr_arbiter: RTL and testbench

//  Shares one hwpe-ctrl style peripheral target port (req/gnt/add/wen/be/data/id,
//  r_data/r_valid/r_id) between N_MST initiators (TB driver, cluster core, debug).

---
 rtl/hci_periph_rr_arbiter_if.sv | 27 ++
 rtl/hci_periph_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_hci_periph_rr_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hci_periph_rr_arbiter_if.sv
// hwpe-ctrl style peripheral bundle, N lanes wide (N=1 for a single target port).
// rdata/r_id are per lane so the initiator side can carry a broadcast copy.
interface hci_periph_rr_arbiter_if #(
    parameter int unsigned N    = 1,
    parameter int unsigned ID_W = 4
);
    logic [N-1:0]      req;
    logic [N-1:0]      gnt;
    logic [N*32-1:0]   add;
    logic [N-1:0]      wen;
    logic [N*4-1:0]    be;
    logic [N*32-1:0]   data;
    logic [N*ID_W-1:0] id;
    logic [N*32-1:0]   r_data;
    logic [N-1:0]      r_valid;
    logic [N*ID_W-1:0] r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );
endinterface

// File: rtl/hci_periph_rr_arbiter.sv
// Round-robin arbiter sharing one peripheral target among N_MST initiators;
// responses are routed back in order through a FIFO of granted indices.
module hci_periph_rr_arbiter #(
    parameter int unsigned N_MST     = 4,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    hci_periph_rr_arbiter_if.slave  mst,
    hci_periph_rr_arbiter_if.master slv,
    output logic                   err_o
);
    localparam int unsigned IDX_W = $clog2(N_MST);
    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {IDLE, LOCKED} state_e;

    state_e           state_q, state_d;
    idx_t             lock_q, lock_d;
    idx_t             rr_ptr_q, rr_ptr_d;
    idx_t             rr_sel, sel;
    logic             found, sel_valid, handshake;
    int unsigned      cand;

    idx_t             fifo_mem [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fifo_full, fifo_empty, push, pop;
    logic             err_q;

    assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTST));
    assign fifo_empty = (cnt_q == '0);

    // First requester at or after rr_ptr, wrapping past the last initiator.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        found  = 1'b0;
        rr_sel = rr_ptr_q;
        cand   = 0;
        for (int unsigned k = 0; k < N_MST; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= N_MST) cand -= N_MST;
            if (!found && mst.req[cand]) begin
                found  = 1'b1;
                rr_sel = idx_t'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        rr_ptr_d  = rr_ptr_q;
        sel       = rr_sel;
        sel_valid = 1'b0;
        unique case (state_q)
            LOCKED: begin
                sel       = lock_q;
                sel_valid = 1'b1;
            end
            default: sel_valid = found && !fifo_full;
        endcase
        handshake = sel_valid & slv.gnt[0];
        if (handshake) begin
            state_d  = IDLE;
            rr_ptr_d = (sel == idx_t'(N_MST - 1)) ? '0 : sel + 1'b1;
        end else if (sel_valid) begin
            state_d = LOCKED;
            lock_d  = sel;
        end
    end

    assign push = handshake;
    assign pop  = slv.r_valid[0] & ~fifo_empty;

    // Target side: idle bus reads as an inactive read with everything else zero.
    always_comb begin
        slv.req  = sel_valid;
        slv.add  = sel_valid ? mst.add[sel*32 +: 32]         : '0;
        slv.wen  = sel_valid ? mst.wen[sel]                  : 1'b1;
        slv.be   = sel_valid ? mst.be[sel*4 +: 4]            : '0;
        slv.data = sel_valid ? mst.data[sel*32 +: 32]        : '0;
        slv.id   = sel_valid ? mst.id[sel*ID_W +: ID_W]      : '0;
        mst.gnt     = '0;
        mst.r_valid = '0;
        if (handshake) mst.gnt[sel] = 1'b1;
        if (pop)       mst.r_valid[fifo_mem[rd_ptr_q]] = 1'b1;
    end

    assign mst.r_data = {N_MST{slv.r_data}};
    assign mst.r_id   = {N_MST{slv.r_id}};
    assign err_o      = err_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            lock_q   <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            rr_ptr_q <= rr_ptr_d;
            if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
            if (slv.r_valid[0] && fifo_empty) err_q <= 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; the occupancy count guards every read of it.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= sel;
    end
endmodule

// File: tb/tb_hci_periph_rr_arbiter.sv
// Directed and randomized bench for hci_periph_rr_arbiter against a queue-based model.
module tb_hci_periph_rr_arbiter;
    localparam int N    = 4;
    localparam int ID_W = 4;
    localparam int MAXO = 2;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic err_o;

    always #5 clk_i = ~clk_i;

    hci_periph_rr_arbiter_if #(.N(N), .ID_W(ID_W)) mst_if ();
    hci_periph_rr_arbiter_if #(.N(1), .ID_W(ID_W)) slv_if ();

    hci_periph_rr_arbiter #(.N_MST(N), .ID_W(ID_W), .MAX_OUTST(MAXO)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .mst    (mst_if),
        .slv    (slv_if),
        .err_o  (err_o)
    );

    // stimulus held by the bench
    logic            t_req [N];
    logic [31:0]     t_add [N];
    logic            t_wen [N];
    logic [3:0]      t_be  [N];
    logic [31:0]     t_data[N];
    logic [ID_W-1:0] t_id  [N];
    logic            t_gnt, t_rvalid;
    logic [31:0]     t_rdata;
    logic [ID_W-1:0] t_rid;

    // reference model: pointer, locked initiator (-1 = none), queue of granted initiators
    int m_ptr, m_lock;
    int m_q[$];
    bit m_err;
    bit e_valid;
    int e_sel;

    int n_assert = 0, n_fail = 0;
    logic            obs_req, obs_wen, obs_err;
    logic [31:0]     obs_add;
    logic [N-1:0]    obs_gnt, obs_rvalid;
    logic [N*32-1:0] obs_rdata;
    logic [N*ID_W-1:0] obs_rid;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            mst_if.req[i]              = t_req[i];
            mst_if.add[i*32 +: 32]     = t_add[i];
            mst_if.wen[i]              = t_wen[i];
            mst_if.be[i*4 +: 4]        = t_be[i];
            mst_if.data[i*32 +: 32]    = t_data[i];
            mst_if.id[i*ID_W +: ID_W]  = t_id[i];
        end
        slv_if.gnt[0]     = t_gnt;
        slv_if.r_valid[0] = t_rvalid;
        slv_if.r_data     = t_rdata;
        slv_if.r_id       = t_rid;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            t_req[i] = 1'b0; t_add[i] = '0; t_wen[i] = 1'b1;
            t_be[i] = '0; t_data[i] = '0; t_id[i] = '0;
        end
        t_gnt = 1'b0; t_rvalid = 1'b0; t_rdata = '0; t_rid = '0;
        apply();
    endtask

    task automatic model_reset();
        m_ptr = 0; m_lock = -1; m_q.delete(); m_err = 1'b0;
    endtask

    task automatic model_eval();
        e_valid = 1'b0;
        e_sel   = 0;
        if (m_lock >= 0) begin
            e_valid = 1'b1;
            e_sel   = m_lock;
        end else if (m_q.size() < MAXO) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!e_valid && t_req[c]) begin
                    e_valid = 1'b1;
                    e_sel   = c;
                end
            end
        end
    endtask

    task automatic model_update();
        if (t_rvalid) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_err = 1'b1;
        end
        if (e_valid && t_gnt) begin
            m_q.push_back(e_sel);
            m_ptr  = (e_sel + 1) % N;
            m_lock = -1;
        end else if (e_valid) begin
            m_lock = e_sel;
        end
    endtask

    // One clock cycle: drive, compare all outputs mid-cycle against the model, advance.
    task automatic step();
        logic [N-1:0] e_gnt, e_rv;
        apply();
        @(negedge clk_i);
        model_eval();
        e_gnt = (e_valid && t_gnt) ? N'(1 << e_sel) : '0;
        e_rv  = (t_rvalid && m_q.size() > 0) ? N'(1 << m_q[0]) : '0;
        obs_req = slv_if.req[0]; obs_add = slv_if.add; obs_wen = slv_if.wen[0];
        obs_gnt = mst_if.gnt; obs_rvalid = mst_if.r_valid; obs_err = err_o;
        obs_rdata = mst_if.r_data; obs_rid = mst_if.r_id;
        check("slv_req",  obs_req, e_valid);
        check("slv_add",  obs_add, e_valid ? t_add[e_sel] : 32'h0);
        check("slv_wen",  obs_wen, e_valid ? t_wen[e_sel] : 1'b1);
        check("slv_be",   slv_if.be, e_valid ? t_be[e_sel] : 4'h0);
        check("slv_data", slv_if.data, e_valid ? t_data[e_sel] : 32'h0);
        check("slv_id",   slv_if.id, e_valid ? t_id[e_sel] : '0);
        check("mst_gnt",  obs_gnt, e_gnt);
        check("mst_rvalid", obs_rvalid, e_rv);
        check("mst_rdata", obs_rdata, {N{t_rdata}});
        check("mst_rid",  obs_rid, {N{t_rid}});
        check("err",      obs_err, m_err);
        @(posedge clk_i);
        #1;
        model_update();
    endtask

    task automatic reset_dut();
        rst_ni = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk_i);
        check("rst_req",    slv_if.req[0], 1'b0);
        check("rst_wen",    slv_if.wen[0], 1'b1);
        check("rst_add",    slv_if.add, 32'h0);
        check("rst_gnt",    mst_if.gnt, 4'b0000);
        check("rst_rvalid", mst_if.r_valid, 4'b0000);
        check("rst_err",    err_o, 1'b0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < N; i++) t_req[i] = 1'b0;
        t_gnt = 1'b0;
        while (m_q.size() > 0) begin
            t_rvalid = 1'b1;
            step();
        end
        t_rvalid = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        reset_dut();

        // single write from mst1, response next cycle
        t_req[1] = 1'b1; t_add[1] = 32'h100; t_data[1] = 32'hCAFE;
        t_wen[1] = 1'b0; t_be[1] = 4'hF; t_gnt = 1'b1;
        step();
        check("t1_add", obs_add, 32'h100);
        check("t1_gnt", obs_gnt, 4'b0010);
        t_req[1] = 1'b0; t_rvalid = 1'b1;
        step();
        check("t1_rvalid", obs_rvalid, 4'b0010);
        t_rvalid = 1'b0;

        // all four requesting, target always grants, response one cycle later
        reset_dut();
        for (int i = 0; i < N; i++) begin
            t_req[i] = 1'b1; t_add[i] = 32'h1000 + 32'(i); t_wen[i] = 1'b0;
        end
        t_gnt = 1'b1;
        for (int c = 0; c < 5; c++) begin
            t_rvalid = (m_q.size() > 0);
            step();
            check("t2_order", 128'(onehot_idx(obs_gnt)), 128'(exp_order[c]));
        end
        drain();

        // mst2 stalled by the target, mst0 arrives meanwhile; selection stays frozen
        t_req[2] = 1'b1; t_add[2] = 32'h200; t_gnt = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin t_req[0] = 1'b1; t_add[0] = 32'h300; end
            step();
            check("t3_hold", obs_add, 32'h200);
            check("t3_nogrant", obs_gnt, 4'b0000);
        end
        t_gnt = 1'b1;
        step();
        check("t3_gnt2", obs_gnt, 4'b0100);
        t_req[2] = 1'b0;
        step();
        check("t3_gnt0", obs_gnt, 4'b0001);
        drain();

        // target withholds responses: FIFO full blocks mst3 until one response
        t_req[1] = 1'b1; t_req[2] = 1'b1; t_gnt = 1'b1;
        step();
        check("t4_gnt1", obs_gnt, 4'b0010);
        t_req[1] = 1'b0;
        step();
        check("t4_gnt2", obs_gnt, 4'b0100);
        t_req[2] = 1'b0; t_req[3] = 1'b1; t_add[3] = 32'h400;
        step();
        check("t4_full_req", obs_req, 1'b0);
        t_rvalid = 1'b1;
        step();
        check("t4_route", obs_rvalid, 4'b0010);
        check("t4_full_req2", obs_req, 1'b0);
        t_rvalid = 1'b0;
        step();
        check("t4_gnt3", obs_gnt, 4'b1000);
        drain();

        // reads from mst1 (id 3) then mst3 (id 5), answered in order
        t_req[1] = 1'b1; t_wen[1] = 1'b1; t_id[1] = 4'd3; t_gnt = 1'b1;
        step();
        check("t5_gnt1", obs_gnt, 4'b0010);
        t_req[1] = 1'b0; t_req[3] = 1'b1; t_wen[3] = 1'b1; t_id[3] = 4'd5;
        step();
        check("t5_gnt3", obs_gnt, 4'b1000);
        t_req[3] = 1'b0; t_rvalid = 1'b1; t_rdata = 32'hA; t_rid = 4'd3;
        step();
        check("t5_rv1", obs_rvalid, 4'b0010);
        check("t5_rdata1", obs_rdata[32 +: 32], 32'hA);
        check("t5_rid1", obs_rid[ID_W +: ID_W], 4'd3);
        t_rdata = 32'hB; t_rid = 4'd5;
        step();
        check("t5_rv3", obs_rvalid, 4'b1000);
        check("t5_rdata3", obs_rdata[96 +: 32], 32'hB);
        check("t5_rid3", obs_rid[3*ID_W +: ID_W], 4'd5);
        t_rvalid = 1'b0; t_rdata = '0; t_rid = '0;

        // stray response with nothing outstanding; then reset mid-transaction
        t_rvalid = 1'b1;
        step();
        t_rvalid = 1'b0;
        step();
        check("t6_err", obs_err, 1'b1);
        step();
        check("t6_err_sticky", obs_err, 1'b1);
        t_req[0] = 1'b1; t_gnt = 1'b1;
        step();
        reset_dut();
        t_rvalid = 1'b1;
        step();
        t_rvalid = 1'b0;
        step();
        check("t6_err_after_rst", obs_err, 1'b1);
        reset_dut();

        // randomized traffic, locked initiator keeps its request stable
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_lock != i) begin
                    t_req[i]  = ($urandom_range(0, 2) == 0);
                    t_add[i]  = $urandom;
                    t_wen[i]  = 1'($urandom_range(0, 1));
                    t_be[i]   = 4'($urandom);
                    t_data[i] = $urandom;
                    t_id[i]   = ID_W'($urandom);
                end
            end
            t_gnt    = ($urandom_range(0, 3) != 0);
            t_rvalid = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
            t_rdata  = $urandom;
            t_rid    = ID_W'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
